bus_xfer_arbiter: RTL and testbench
===================================

// Module: bus_xfer_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer for the shared 8-bit bus feeding the REGISTER8-style
//   register bank (ld/inc/clr). Up to N_REQ requesters each ask for one transfer:
//   load data into, or increment, one of N_DST destination registers.
//   Grants one requester at a time, drives the bus and emits one-cycle ld/inc strobes.
//   Handshakes completion back with a done pulse.
// PARAMETERS
//   N_REQ   4   number of requesters (2..8)
//   N_DST   4   number of destination registers (power of 2, 2..8)
//   DATA_W  8   bus/data width
//   DST_W   2   clog2(N_DST), width of each destination select
// PORTS
//   clk       in   1             clock, rising edge
//   clr       in   1             reset, asynchronous, active-high
//   halt      in   1             1 = do not start new transfers; an in-flight one completes
//   req       in   N_REQ         per-requester request level
//   req_data  in   N_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//   req_dst   in   N_REQ*DST_W   requester i destination index at [i*DST_W +: DST_W]
//   req_op    in   N_REQ         requester i op: 0 = load, 1 = increment
//   gnt       out  N_REQ         one-hot grant, registered
//   done      out  N_REQ         one-hot, one-cycle completion pulse, registered
//   bus_data  out  DATA_W        shared bus value presented to destination 'in' ports
//   dst_ld    out  N_DST         one-hot load strobe to destination registers
//   dst_inc   out  N_DST         one-hot increment strobe to destination registers
//   busy      out  1             1 whenever state != IDLE
// BEHAVIOUR
//   - All outputs registered. On clr: state=IDLE, ptr=0, gnt=0, done=0, bus_data=0,
//     dst_ld=0, dst_inc=0, busy=0.
//   - FSM states, one per cycle after IDLE: IDLE -> XFER -> ACK -> IDLE.
//   - IDLE: if halt=0 and |req, pick the winner w: the first set req at or above ptr,
//     searching upward with wrap modulo N_REQ.
//     At that edge: gnt=onehot(w), bus_data=req_data[w], busy=1, state=XFER.
//     If req_op[w]=0, dst_ld=onehot(req_dst[w]); else dst_inc=onehot(req_dst[w]) and bus_data=0.
//     Requester's data/dst/op are sampled only at this edge; later changes are ignored.
//   - XFER (exactly 1 cycle): the strobe and bus_data are held stable, so the destination
//     captures at the closing edge. At that edge: dst_ld=dst_inc=0, done=onehot(w), state=ACK.
//     bus_data holds its value.
//   - ACK (1 cycle): at its closing edge: done=0, gnt=0, busy=0, bus_data=0,
//     ptr=(w+1) mod N_REQ, state=IDLE.
//   - Latency: req high in IDLE at edge n -> strobe high in cycle n..n+1 -> done high in
//     cycle n+1..n+2. Throughput is one transfer per 3 cycles.
//   - Requester must drop req in the cycle done is seen. A req still high when IDLE is
//     re-entered is a new request and is served by round-robin order.
//   - At most one bit of gnt, done, dst_ld or dst_inc is ever set. dst_ld and dst_inc are
//     never both nonzero.
//   - req deasserted after grant: the transfer still completes (no abort).
//   - halt rising during XFER/ACK: the current transfer completes; stay in IDLE while halt=1.
//   - clr mid-transfer: immediate return to reset values. No strobe or done is produced
//     after clr rises; the destination is not updated if clr precedes the XFER closing edge.
//   - Destination index >= N_DST cannot occur (power-of-2 N_DST); req_dst is used directly.
// TESTING
//   1. Single load: req=0001, data0=8'hA5, dst0=2, op0=0 -> next cycle gnt=0001,
//      dst_ld=0100, bus_data=A5; following cycle done=0001; then busy=0, ptr=1.
//   2. Increment: req=0100, dst2=1, op2=1 -> dst_inc=0010 for one cycle, dst_ld=0,
//      bus_data=0, done=0100.
//   3. Fairness: all four req held high from reset -> grant order 0,1,2,3,0 with
//      3-cycle spacing; no requester granted twice before all others are served.
//   4. Wrap: ptr=3, req=1001 -> req3 served first, then req0.
//   5. halt=1 with req=1111 -> busy stays 0 for 10 cycles; halt falls -> grant to ptr position.
//   6. clr asserted in XFER cycle -> all outputs 0 same cycle (async), no done pulse,
//      ptr=0 afterwards.

Source files
------------

// File: rtl/bus_xfer_arbiter.sv
// Round-robin sequencer for the shared register-bank bus: grants one requester,
// drives one ld/inc strobe for a cycle, then pulses done back to that requester.
module bus_xfer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_DST  = 4,
  parameter int DATA_W = 8,
  parameter int DST_W  = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    halt,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*DST_W-1:0]  req_dst,
  input  logic [N_REQ-1:0]        req_op,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       bus_data,
  output logic [N_DST-1:0]        dst_ld,
  output logic [N_DST-1:0]        dst_inc,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [PTR_W-1:0]    win_reg, win_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic [N_REQ-1:0]    done_reg, done_next;
  logic [DATA_W-1:0]   bus_reg, bus_next;
  logic [N_DST-1:0]    ld_reg, ld_next;
  logic [N_DST-1:0]    inc_reg, inc_next;
  logic                busy_reg, busy_next;

  logic [DATA_W-1:0]   data_arr [N_REQ];
  logic [DST_W-1:0]    dst_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign dst_arr[gi]  = req_dst[gi*DST_W +: DST_W];
    end
  endgenerate

  // Search upward from ptr with wrap; iterating from the far end lets the
  // nearest set request overwrite any farther one.
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   sum;

  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N_REQ)) begin
        sum = sum - (PTR_W + 1)'(N_REQ);
      end
      if (req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = sum[PTR_W-1:0];
      end
    end
  end

  logic [N_DST-1:0] dst_hot;
  logic [N_REQ-1:0] win_hot;

  assign dst_hot = N_DST'(1) << dst_arr[win];
  assign win_hot = N_REQ'(1) << win;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    gnt_next   = gnt_reg;
    done_next  = done_reg;
    bus_next   = bus_reg;
    ld_next    = ld_reg;
    inc_next   = inc_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (!halt && found) begin
          state_next = XFER;
          win_next   = win;
          gnt_next   = win_hot;
          busy_next  = 1'b1;
          done_next  = '0;
          if (req_op[win]) begin
            inc_next = dst_hot;
            ld_next  = '0;
            bus_next = '0;
          end else begin
            ld_next  = dst_hot;
            inc_next = '0;
            bus_next = data_arr[win];
          end
        end
      end
      XFER: begin
        // The destination captures at this edge; bus_data is left as-is.
        ld_next    = '0;
        inc_next   = '0;
        done_next  = gnt_reg;
        state_next = ACK;
      end
      ACK: begin
        done_next  = '0;
        gnt_next   = '0;
        busy_next  = 1'b0;
        bus_next   = '0;
        ptr_next   = (win_reg == PTR_W'(N_REQ - 1)) ? '0 : win_reg + 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      bus_reg   <= '0;
      ld_reg    <= '0;
      inc_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      bus_reg   <= bus_next;
      ld_reg    <= ld_next;
      inc_reg   <= inc_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign bus_data = bus_reg;
  assign dst_ld   = ld_reg;
  assign dst_inc  = inc_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Bench for bus_xfer_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bus_xfer_arbiter;

  localparam int N_REQ  = 4;
  localparam int N_DST  = 4;
  localparam int DATA_W = 8;
  localparam int DST_W  = 2;

  logic                    clk = 1'b0;
  logic                    clr = 1'b1;
  logic                    halt = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ*DST_W-1:0]  req_dst = '0;
  logic [N_REQ-1:0]        req_op = '0;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       bus_data;
  logic [N_DST-1:0]        dst_ld;
  logic [N_DST-1:0]        dst_inc;
  logic                    busy;

  bus_xfer_arbiter #(
    .N_REQ(N_REQ), .N_DST(N_DST), .DATA_W(DATA_W), .DST_W(DST_W)
  ) dut (
    .clk(clk), .clr(clr), .halt(halt), .req(req), .req_data(req_data),
    .req_dst(req_dst), .req_op(req_op), .gnt(gnt), .done(done),
    .bus_data(bus_data), .dst_ld(dst_ld), .dst_inc(dst_inc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output snapshot for one cycle.
  typedef struct packed {
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  done;
    logic [DATA_W-1:0] bus;
    logic [N_DST-1:0]  ld;
    logic [N_DST-1:0]  inc;
    logic              busy;
  } snap_t;

  snap_t mq[$];
  snap_t ex, e1, e2;
  int    mptr = 0;
  int    m_w, m_i, m_dst;
  logic  m_op;

  // Model: a granted transfer is a fixed 3-cycle script of snapshots queued at
  // the decision edge; an empty queue means the arbiter is free to decide.
  always @(posedge clk) begin
    #1;
    if (clr) begin
      mq.delete();
      mptr = 0;
      ex = '0;
    end else if (mq.size() > 0) begin
      ex = mq.pop_front();
    end else begin
      ex = '0;
      if (!halt && req != '0) begin
        m_w = -1;
        for (int k = 0; k < N_REQ; k++) begin
          m_i = (mptr + k) % N_REQ;
          if (m_w < 0 && req[m_i]) m_w = m_i;
        end
        m_op  = req_op[m_w];
        m_dst = int'(req_dst[m_w*DST_W +: DST_W]);
        e1 = '0;
        e1.gnt  = N_REQ'(1) << m_w;
        e1.busy = 1'b1;
        if (m_op) begin
          e1.inc = N_DST'(1) << m_dst;
        end else begin
          e1.ld  = N_DST'(1) << m_dst;
          e1.bus = req_data[m_w*DATA_W +: DATA_W];
        end
        e2 = '0;
        e2.gnt  = e1.gnt;
        e2.done = e1.gnt;
        e2.bus  = e1.bus;
        e2.busy = 1'b1;
        ex = e1;
        mq.push_back(e2);
        mq.push_back(snap_t'(0));
        mptr = (m_w + 1) % N_REQ;
        $display("xfer: req%0d op=%0d dst=%0d bus=%0h", m_w, m_op, m_dst, e1.bus);
      end
    end
    chk("m_gnt",  32'(gnt),      32'(ex.gnt));
    chk("m_done", 32'(done),     32'(ex.done));
    chk("m_bus",  32'(bus_data), 32'(ex.bus));
    chk("m_ld",   32'(dst_ld),   32'(ex.ld));
    chk("m_inc",  32'(dst_inc),  32'(ex.inc));
    chk("m_busy", 32'(busy),     32'(ex.busy));
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  int fair_idx[$];
  int fair_cyc[$];
  logic [N_REQ-1:0] prev_gnt;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    negs(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus", 32'(bus_data), 0);
    clr = 1'b0;

    // Single load
    req_data[7:0] = 8'hA5; req_dst[1:0] = 2'd2; req_op[0] = 1'b0; req = 4'b0001;
    negs(1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_ld", 32'(dst_ld), 32'h4);
    chk("t1_bus", 32'(bus_data), 32'hA5);
    chk("t1_busy", 32'(busy), 1);
    req = '0;
    negs(1);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_ld_off", 32'(dst_ld), 0);
    chk("t1_bus_hold", 32'(bus_data), 32'hA5);
    negs(1);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_gnt", 32'(gnt), 0);

    // Increment; req0 also set, so ptr=1 must pick req2
    req_dst[5:4] = 2'd1; req_op[2] = 1'b1; req_data[23:16] = 8'h77; req = 4'b0101;
    negs(1);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_inc", 32'(dst_inc), 32'h2);
    chk("t2_ld", 32'(dst_ld), 0);
    chk("t2_bus", 32'(bus_data), 0);
    req = '0;
    negs(1);
    chk("t2_done", 32'(done), 32'h4);
    negs(1);

    // Wrap: ptr=3
    req_op = '0; req_data = {8'h33, 8'h22, 8'h11, 8'h10}; req = 4'b1001;
    negs(1);
    chk("t4_gnt3", 32'(gnt), 32'h8);
    chk("t4_bus3", 32'(bus_data), 32'h33);
    req = 4'b0001;
    negs(3);
    chk("t4_gnt0", 32'(gnt), 32'h1);
    chk("t4_bus0", 32'(bus_data), 32'h10);
    req = '0;
    negs(2);

    // Halt: ptr=1
    halt = 1'b1; req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      negs(1);
      chk("t5_halt_busy", 32'(busy), 0);
    end
    halt = 1'b0;
    negs(1);
    chk("t5_gnt", 32'(gnt), 32'h2);
    req = '0;
    negs(3);

    // Fairness from reset
    clr = 1'b1;
    negs(1);
    clr = 1'b0; req = 4'b1111; prev_gnt = '0;
    for (int c = 0; c < 16; c++) begin
      negs(1);
      if (gnt != '0 && prev_gnt == '0) begin
        for (int b = 0; b < N_REQ; b++) if (gnt[b]) fair_idx.push_back(b);
        fair_cyc.push_back(c);
      end
      prev_gnt = gnt;
    end
    chk("t3_count", 32'(fair_idx.size() >= 5), 1);
    for (int k = 0; k < 5 && k < fair_idx.size(); k++) begin
      chk("t3_order", 32'(fair_idx[k]), 32'(exp_order[k]));
      if (k > 0) chk("t3_spacing", 32'(fair_cyc[k] - fair_cyc[k-1]), 3);
    end
    req = '0;
    negs(3);

    // clr during XFER
    req_data[7:0] = 8'h5C; req = 4'b0001;
    negs(1);
    chk("t6_gnt", 32'(gnt), 32'h1);
    #2 clr = 1'b1;
    #1;
    chk("t6_async_gnt", 32'(gnt), 0);
    chk("t6_async_ld", 32'(dst_ld), 0);
    chk("t6_async_bus", 32'(bus_data), 0);
    chk("t6_async_busy", 32'(busy), 0);
    req = '0;
    negs(1);
    chk("t6_no_done", 32'(done), 0);
    clr = 1'b0; req = 4'b0011;
    negs(1);
    chk("t6_ptr0", 32'(gnt), 32'h1);
    req = '0;
    negs(3);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      negs(1);
      if (clr) clr = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          req_dst[i*DST_W +: DST_W]    = DST_W'($urandom);
          req_op[i]                    = 1'($urandom);
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      halt = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 99) == 0) clr = 1'b1;
    end
    clr = 1'b0; halt = 1'b0; req = '0;
    negs(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
